// File: rtl/ntt_engine_param.sv
// ntt_engine_param: iterative radix-2 forward/inverse NTT with one 3-stage butterfly and streamed I/O.
// Define NTT_INV_SCALE_EN to multiply inverse-mode outputs by NINV on unload.
module ntt_engine_param #(
  parameter int LOG_N = 4,
  parameter int W     = 16,
  parameter int Q     = 3329,
  parameter int NINV  = 3121
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [LOG_N-1:0] tw_addr,
  output logic             tw_inv,
  input  logic [W-1:0]     tw_data,
  output logic             busy,
  output logic             done
);
  localparam int N  = 1 << LOG_N;
  localparam int CW = LOG_N + 1;
  localparam logic [W-1:0]   QW = W'(Q);
  localparam logic [2*W-1:0] QX = (2*W)'(Q);
  localparam logic [W-1:0]   NW = W'(NINV % Q);
`ifdef NTT_INV_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, COMP, DRAIN, UNLOAD} state_t;

  state_t           state_q, state_d;
  logic             mode_q, v1_q, v2_q, out_valid_q, done_q;
  logic [CW-1:0]    cnt_q;
  logic [LOG_N-1:0] bf_q, ia1_q, ib1_q, ia2_q, ib2_q;
  logic [3:0]       s_q, lm;
  logic [1:0]       dr_q;
  logic [W-1:0]     ram_q [N];
  logic [W-1:0]     a1_q, b1_q, x2_q, out_data_q;
  logic [2*W-1:0]   p2_q;
  logic [LOG_N-1:0] m, lo, ia, ib, ld_addr, rd_addr;
  logic [W-1:0]     t2, wa, wb, rd;
  logic             last_bf, last_dr, last_out, out_adv, out_hs;

  function automatic logic [LOG_N-1:0] brev(input logic [LOG_N-1:0] x);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = x[LOG_N-1-i];
    return r;
  endfunction

  function automatic logic [W-1:0] add_q(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y};
    return (t >= {1'b0, QW}) ? W'(t - {1'b0, QW}) : W'(t);
  endfunction

  function automatic logic [W-1:0] sub_q(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x >= y) ? x - y : QW - (y - x);
  endfunction

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  // Butterfly b maps to pair (k, k+m): insert a zero at bit log2(m) of b.
  assign lm      = mode_q ? 4'(LOG_N - 1) - s_q : s_q;
  assign m       = LOG_N'(1) << lm;
  assign lo      = bf_q & (m - LOG_N'(1));
  assign ia      = ((bf_q >> lm) << (lm + 4'd1)) | lo;
  assign ib      = ia | m;
  assign ld_addr = mode_q ? cnt_q[LOG_N-1:0] : brev(cnt_q[LOG_N-1:0]);
  assign rd_addr = mode_q ? brev(cnt_q[LOG_N-1:0]) : cnt_q[LOG_N-1:0];
  assign rd      = ram_q[rd_addr];
  assign t2      = W'(p2_q % QX);
  assign wa      = mode_q ? x2_q : add_q(x2_q, t2);
  assign wb      = mode_q ? t2 : sub_q(x2_q, t2);
  assign last_bf  = bf_q == LOG_N'(N / 2 - 1);
  assign last_dr  = dr_q == 2'd2;
  assign last_out = cnt_q == CW'(N);
  assign out_hs   = out_valid_q && out_ready;
  assign out_adv  = !out_valid_q || out_ready;

  assign in_ready  = state_q == LOAD;
  assign busy      = state_q != IDLE;
  assign tw_addr   = (state_q == COMP) ? (m | lo) : '0;
  assign tw_inv    = mode_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = (in_valid && cnt_q == CW'(N - 1)) ? COMP : LOAD;
      COMP:    state_d = last_bf ? DRAIN : COMP;
      DRAIN:   state_d = !last_dr ? DRAIN : (s_q == 4'(LOG_N - 1)) ? UNLOAD : COMP;
      UNLOAD:  state_d = (out_hs && last_out) ? IDLE : UNLOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      bf_q        <= '0;
      s_q         <= '0;
      dr_q        <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) mode_q <= mode;
      cnt_q <= ((state_q == LOAD && in_valid) || (state_q == UNLOAD && out_adv && !last_out)) ? cnt_q + CW'(1)
             : (state_q == LOAD || state_q == UNLOAD) ? cnt_q : '0;
      bf_q   <= (state_q == COMP && !last_bf) ? bf_q + LOG_N'(1) : '0;
      dr_q   <= (state_q == DRAIN && !last_dr) ? dr_q + 2'd1 : '0;
      s_q    <= (state_q == IDLE) ? '0 : (state_q == DRAIN && last_dr) ? s_q + 4'd1 : s_q;
      v1_q   <= state_q == COMP;
      v2_q   <= v1_q;
      done_q <= state_q == UNLOAD && out_hs && last_out;
      if (state_q == UNLOAD && out_adv) begin
        out_valid_q <= !last_out;
        if (!last_out) out_data_q <= (SCALE && mode_q) ? W'(mul(rd, NW) % QX) : rd;
      end
    end
  end

  // Stage 0 reads the pair, stage 1 multiplies with the returned twiddle, stage 2 reduces and writes back.
  always_ff @(posedge clk) begin
    a1_q  <= ram_q[ia];
    b1_q  <= ram_q[ib];
    ia1_q <= ia;
    ib1_q <= ib;
    ia2_q <= ia1_q;
    ib2_q <= ib1_q;
    x2_q  <= mode_q ? add_q(a1_q, b1_q) : a1_q;
    p2_q  <= mul(mode_q ? sub_q(a1_q, b1_q) : b1_q, tw_data);
    if (state_q == LOAD && in_valid) begin
      ram_q[ld_addr] <= in_data % QW;
    end else if (v2_q) begin
      ram_q[ia2_q] <= wa;
      ram_q[ib2_q] <= wb;
    end
  end
endmodule

// File: tb/tb_ntt_engine_param.sv
// tb_ntt_engine_param: directed NTT/INTT jobs checked against hand values and a direct-DFT reference.
// Expectations for inverse jobs follow NTT_INV_SCALE_EN when the bench is built with it.
module tb_ntt_engine_param;
  localparam int LOG_N = 4, N = 16, W = 16, Q = 3329, NINV = 3121;
`ifdef NTT_INV_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, tw_inv, busy, done;
  logic [W-1:0] in_data = '0, out_data, tw_data = '0;
  logic [LOG_N-1:0] tw_addr;
  int n_tests = 0, n_fail = 0;
  int wp [2][N];
  int rom [2][N];

  ntt_engine_param #(.LOG_N(LOG_N), .W(W), .Q(Q), .NINV(NINV)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tw_addr(tw_addr), .tw_inv(tw_inv), .tw_data(tw_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Twiddle ROM: entry m+j holds root^(j*N/(2m)), one-cycle read latency.
  always @(posedge clk) tw_data <= W'(rom[tw_inv][tw_addr]);

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mpow(input int b, input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return int'(r);
  endfunction

  task automatic ref_ntt(input bit inv, input int x[N], output int y[N]);
    for (int k = 0; k < N; k++) begin
      longint acc = 0;
      for (int n = 0; n < N; n++) acc = (acc + longint'(x[n] % Q) * wp[inv][(n * k) % N]) % Q;
      y[k] = (inv && SCALE) ? int'(acc * NINV % Q) : int'(acc);
    end
  endtask

  task automatic run_job(input bit inv, input int din[N], input bit rnd, input int poke, input int abort,
                         output int dout[N], output int cyc);
    int ii = 0, oi = 0, pd = 0;
    bit stall = 1'b0, rdy;
    cyc = 0;
    for (int k = 0; k < N; k++) dout[k] = -1;
    @(negedge clk);
    start = 1'b1;
    mode = inv;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = (c == poke);
      if (c == poke) mode = !inv;
      if (c == abort) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        return;
      end
      if (done) begin
        cyc = c;
        break;
      end
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (oi < N) dout[oi] = out_data;
        oi++;
      end
      stall = out_valid && !rdy;
      pd = out_data;
      in_valid = 1'b1;
      in_data = W'(ii < N ? din[ii] : 12345);
      if (in_ready) ii++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    check("n_out", oi, N);
    if (cyc == 0) check("timeout", 0, 1);
  endtask

  initial begin
    int x[N], y[N], e[N], r[N];
    int cyc, w, m;
    w = mpow(17, 256 / N);
    for (int i = 0; i < N; i++) begin
      wp[0][i] = mpow(w, i);
      wp[1][i] = mpow(w, (N - i) % N);
    end
    for (int v = 0; v < 2; v++) begin
      rom[v][0] = 0;
      for (int i = 1; i < N; i++) begin
        m = 1;
        while (2 * m <= i) m *= 2;
        rom[v][i] = wp[v][(i - m) * N / (2 * m)];
      end
    end

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_tw_addr", tw_addr, 0);
    check("rst_tw_inv", tw_inv, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    x = '{default: 0};
    x[0] = 1;
    run_job(1'b0, x, 1'b0, 0, 0, y, cyc);
    check("impulse_cycles", cyc, 78);
    for (int k = 0; k < N; k++) check($sformatf("impulse[%0d]", k), y[k], 1);

    x = '{default: 1};
    run_job(1'b0, x, 1'b0, 0, 0, y, cyc);
    for (int k = 0; k < N; k++) check($sformatf("ones[%0d]", k), y[k], k == 0 ? 16 : 0);

    x = '{default: 0};
    x[0] = 16;
    run_job(1'b1, x, 1'b0, 0, 0, y, cyc);
    check("inv_cycles", cyc, 78);
    for (int k = 0; k < N; k++) check($sformatf("inv_dc[%0d]", k), y[k], SCALE ? 1 : 16);

    x = '{default: 0};
    x[0] = 65535;
    run_job(1'b0, x, 1'b1, 0, 0, y, cyc);
    for (int k = 0; k < N; k++) check($sformatf("big_in[%0d]", k), y[k], 2284);

    for (int k = 0; k < N; k++) x[k] = int'($urandom_range(0, Q - 1));
    run_job(1'b0, x, 1'b0, 0, 26, y, cyc);
    run_job(1'b0, x, 1'b0, 30, 0, y, cyc);
    check("poke_cycles", cyc, 78);
    ref_ntt(1'b0, x, e);
    for (int k = 0; k < N; k++) check($sformatf("fwd_rand[%0d]", k), y[k], e[k]);

    run_job(1'b1, y, 1'b1, 0, 0, r, cyc);
    ref_ntt(1'b1, y, e);
    for (int k = 0; k < N; k++) begin
      check($sformatf("inv_ref[%0d]", k), r[k], e[k]);
      check($sformatf("round_trip[%0d]", k), r[k], SCALE ? x[k] : (16 * x[k]) % Q);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
